cci_mpf_shim_tx_buffer: RTL and testbench
=========================================

Name: cci_mpf_shim_tx_buffer

Overview:
- MPF shim between the AFU-facing and FIU-facing cci_mpf_if instances.
- Absorbs c0Tx (read) and c1Tx (write) requests in per-channel FIFOs and drains each FIFO toward the FIU only while that channel's FIU almost-full is low.
- Drives its own early almost-full to the AFU, so AFU-side logic gets THRESH cycles of slack independent of FIU pipeline depth.
- Registers the c2Tx, c0Rx and c1Rx paths by one cycle and forwards reset toward the AFU.

Parameters:
- DEPTH, 16, entries per channel FIFO; power of 2, at least 8.
- THRESH, 4, free-slot margin; the AFU almost-full for a channel is high when occupancy >= DEPTH-THRESH.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset for all state.
- fiu  cci_mpf_if.to_fiu  interface  FIU-side connection; drives c0Tx/c1Tx/c2Tx, samples c0TxAlmFull/c1TxAlmFull/c0Rx/c1Rx.
- afu  cci_mpf_if.to_afu  interface  AFU-side connection; samples c0Tx/c1Tx/c2Tx, drives c0TxAlmFull/c1TxAlmFull/c0Rx/c1Rx/reset.
- overflow_err  output  2  sticky flags; bit0 = c0, bit1 = c1; an AFU request arrived with its FIFO full.

Behaviour:
- Reset (async assert, released on a clk edge):
  - FIFOs empty; all output valid fields 0.
  - overflow_err = 0.
  - afu.reset = 1 while reset is high, then follows reset registered one cycle.
  - afu.c0TxAlmFull = afu.c1TxAlmFull = 1 while reset is high; both deassert the first cycle after release, since occupancy is 0.
- Enqueue: an AFU request with valid=1 is written the same cycle if count < DEPTH, or if count == DEPTH and a dequeue occurs that cycle.
- Overflow: a valid request with the FIFO full and no dequeue is dropped and sets the channel's overflow_err bit. The bit stays set until reset.
- Dequeue:
  - When the FIFO is non-empty and fiu.cXTxAlmFull was 0, the head drives fiu.cXTx with valid=1.
  - Otherwise fiu.cXTx.valid=0 and the payload is don't-care.
  - One entry per cycle per channel.
  - CCI-P tolerates requests after almost-full rises, so no stop-on-edge handling is needed.
- Latency: a request enqueued in cycle N appears on fiu at the earliest in cycle N+1 (empty FIFO, FIU almost-full low). There is no same-cycle bypass.
- Ordering: strict FIFO within a channel; no ordering between c0 and c1.
- Multi-line c1 writes: each beat is one entry. Beats pass in order; no grouping.
- Occupancy counter: width $clog2(DEPTH)+1. Read/write pointers are $clog2(DEPTH) bits and wrap naturally.
- AFU almost-full: afu.cXTxAlmFull is registered from the next-state count and is high when count >= DEPTH-THRESH.
- c2Tx (MMIO response): registered one cycle, fiu.c2Tx = previous afu.c2Tx, with no flow control. Its valid field is cleared on reset.
- c0Rx/c1Rx: registered one cycle, afu.cXRx = previous fiu.cXRx. Valid fields are cleared on reset. No buffering; responses are never dropped.
- Reset mid-operation: all buffered requests are discarded; there is no drain. Responses in the Rx registers are lost.

Decomposition:
- Shared package cci_mpf_shim_tx_buffer_pkg holds:
  - default DEPTH and THRESH localparams;
  - t_tx_buffer_err, a 2-bit packed struct with c0 and c1 fields.
- Payload types come from cci_mpf_if_pkg.
- One sub-module, cci_mpf_shim_tx_fifo:
  - parameters N_DATA_BITS, DEPTH, THRESH;
  - ports: enq_en, enq_data, deq_en, first, notEmpty, almostFull, full.
  - Instantiated twice with $bits(t_if_cci_mpf_c0_Tx) and $bits(t_if_cci_mpf_c1_Tx).

Test Plan:
- Reset: hold reset high 3 cycles, then release -> every fiu/afu valid is 0 during reset; both afu almost-fulls are 1 during reset and 0 on the first post-reset cycle; overflow_err = 0.
- Pass-through: one c0 read at cycle 10 with fiu almost-full low -> the same payload appears on fiu.c0Tx at cycle 11 with valid=1; valid=0 in all other cycles.
- Backpressure: hold fiu.c1TxAlmFull=1 and send 12 writes (DEPTH=16, THRESH=4) -> afu.c1TxAlmFull rises the cycle after the 12th enqueue; no fiu.c1Tx valid. Then release -> 12 writes emerge on consecutive cycles in order, and afu almost-full drops once occupancy is below 12.
- Overflow: keep fiu almost-full high and send 17 c0 requests -> the 17th is dropped and overflow_err becomes 2'b01. After release exactly 16 requests emerge, and overflow_err stays 2'b01.
- Full with simultaneous enq/deq: FIFO full, fiu almost-full low, AFU sends one request -> it is accepted, count stays 16, overflow_err stays 0.
- Response path and mid-run reset: a c0Rx response at cycle N appears on afu.c0Rx at N+1. Asserting reset with 5 buffered writes -> no buffered write ever reaches fiu after reset.

Source files
------------

// File: rtl/cci_mpf_if_pkg.sv
// Reduced CCI-P/MPF payload types shared by the AFU- and FIU-facing interfaces.
package cci_mpf_if_pkg;

  localparam int unsigned CCI_ADDR_WIDTH  = 42;
  localparam int unsigned CCI_MDATA_WIDTH = 16;
  localparam int unsigned CCI_DATA_WIDTH  = 64;
  localparam int unsigned CCI_TID_WIDTH   = 9;

  typedef struct packed {
    logic [CCI_ADDR_WIDTH-1:0]  addr;
    logic [CCI_MDATA_WIDTH-1:0] mdata;
    logic                       valid;
  } t_if_cci_mpf_c0_Tx;

  typedef struct packed {
    logic [CCI_ADDR_WIDTH-1:0]  addr;
    logic [CCI_MDATA_WIDTH-1:0] mdata;
    logic [CCI_DATA_WIDTH-1:0]  data;
    logic                       sop;
    logic                       valid;
  } t_if_cci_mpf_c1_Tx;

  typedef struct packed {
    logic [CCI_TID_WIDTH-1:0]  tid;
    logic [CCI_DATA_WIDTH-1:0] data;
    logic                      valid;
  } t_if_cci_c2_Tx;

  typedef struct packed {
    logic [CCI_MDATA_WIDTH-1:0] mdata;
    logic [CCI_DATA_WIDTH-1:0]  data;
    logic                       valid;
  } t_if_cci_c0_Rx;

  typedef struct packed {
    logic [CCI_MDATA_WIDTH-1:0] mdata;
    logic                       valid;
  } t_if_cci_c1_Rx;

endpackage

// File: rtl/cci_mpf_shim_tx_buffer_pkg.sv
// Defaults and error-flag layout for the Tx buffering shim.
package cci_mpf_shim_tx_buffer_pkg;

  localparam int unsigned TX_BUF_DEPTH  = 16;
  localparam int unsigned TX_BUF_THRESH = 4;

  // bit0 = c0 (reads), bit1 = c1 (writes)
  typedef struct packed {
    logic c1;
    logic c0;
  } t_tx_buffer_err;

endpackage

// File: rtl/cci_mpf_if.sv
// One MPF connection point; to_fiu is the view of a shim looking toward the FIU.
interface cci_mpf_if;
  import cci_mpf_if_pkg::*;

  logic              reset;
  t_if_cci_mpf_c0_Tx c0Tx;
  t_if_cci_mpf_c1_Tx c1Tx;
  t_if_cci_c2_Tx     c2Tx;
  logic              c0TxAlmFull;
  logic              c1TxAlmFull;
  t_if_cci_c0_Rx     c0Rx;
  t_if_cci_c1_Rx     c1Rx;

  modport to_fiu (
    input  reset,
    output c0Tx, c1Tx, c2Tx,
    input  c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
  );

  modport to_afu (
    output reset,
    input  c0Tx, c1Tx, c2Tx,
    output c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
  );
endinterface

// File: rtl/cci_mpf_shim_tx_fifo.sv
// Per-channel request FIFO with a registered early almost-full.
module cci_mpf_shim_tx_fifo #(
  parameter int unsigned N_DATA_BITS = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned THRESH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_en,
  input  logic [N_DATA_BITS-1:0] enq_data,
  input  logic                   deq_en,
  output logic [N_DATA_BITS-1:0] first,
  output logic                   notEmpty,
  output logic                   almostFull,
  output logic                   full
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [N_DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_next;
  logic                   do_enq;
  logic                   do_deq;

  assign notEmpty = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign first    = mem[rd_ptr];

  // A full FIFO still accepts a write in a cycle that also pops the head
  always_comb begin
    do_deq     = deq_en && notEmpty;
    do_enq     = enq_en && (!full || do_deq);
    count_next = count;
    if (do_enq && !do_deq) begin
      count_next = count + CNT_W'(1);
    end else if (!do_enq && do_deq) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wr_ptr] <= enq_data;
    end
  end

  // Pointers and occupancy; pointers wrap at DEPTH naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Almost-full looks at next-state occupancy; held high through reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      almostFull <= 1'b1;
    end else begin
      almostFull <= (count_next >= CNT_W'(DEPTH - THRESH));
    end
  end
endmodule

// File: rtl/cci_mpf_shim_tx_buffer.sv
// MPF shim: buffers c0/c1 requests toward the FIU and presents its own early
// almost-full to the AFU; c2Tx and the Rx paths are simply retimed by one cycle.
module cci_mpf_shim_tx_buffer
  import cci_mpf_if_pkg::*;
  import cci_mpf_shim_tx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = TX_BUF_DEPTH,
  parameter int unsigned THRESH = TX_BUF_THRESH
) (
  input  logic       clk,
  input  logic       reset,
  cci_mpf_if.to_fiu  fiu,
  cci_mpf_if.to_afu  afu,
  output logic [1:0] overflow_err
);
  localparam int unsigned C0_BITS = $bits(t_if_cci_mpf_c0_Tx);
  localparam int unsigned C1_BITS = $bits(t_if_cci_mpf_c1_Tx);

  logic               reset_q;
  logic               c0_fiu_alm_q;
  logic               c1_fiu_alm_q;
  logic               c0_deq;
  logic               c1_deq;
  logic               c0_not_empty;
  logic               c1_not_empty;
  logic               c0_full;
  logic               c1_full;
  logic               c0_alm;
  logic               c1_alm;
  logic [C0_BITS-1:0] c0_first;
  logic [C1_BITS-1:0] c1_first;
  t_if_cci_mpf_c0_Tx  c0_head;
  t_if_cci_mpf_c1_Tx  c1_head;
  t_tx_buffer_err     err_q;
  t_if_cci_c2_Tx      c2_tx_q;
  t_if_cci_c0_Rx      c0_rx_q;
  t_if_cci_c1_Rx      c1_rx_q;

  cci_mpf_shim_tx_fifo #(
    .N_DATA_BITS (C0_BITS),
    .DEPTH       (DEPTH),
    .THRESH      (THRESH)
  ) c0_fifo (
    .clk        (clk),
    .reset      (reset),
    .enq_en     (afu.c0Tx.valid),
    .enq_data   (afu.c0Tx),
    .deq_en     (c0_deq),
    .first      (c0_first),
    .notEmpty   (c0_not_empty),
    .almostFull (c0_alm),
    .full       (c0_full)
  );

  cci_mpf_shim_tx_fifo #(
    .N_DATA_BITS (C1_BITS),
    .DEPTH       (DEPTH),
    .THRESH      (THRESH)
  ) c1_fifo (
    .clk        (clk),
    .reset      (reset),
    .enq_en     (afu.c1Tx.valid),
    .enq_data   (afu.c1Tx),
    .deq_en     (c1_deq),
    .first      (c1_first),
    .notEmpty   (c1_not_empty),
    .almostFull (c1_alm),
    .full       (c1_full)
  );

  // FIU almost-full as seen last cycle gates this cycle's dequeue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c0_fiu_alm_q <= 1'b1;
      c1_fiu_alm_q <= 1'b1;
    end else begin
      c0_fiu_alm_q <= fiu.c0TxAlmFull;
      c1_fiu_alm_q <= fiu.c1TxAlmFull;
    end
  end

  assign c0_deq = c0_not_empty && !c0_fiu_alm_q;
  assign c1_deq = c1_not_empty && !c1_fiu_alm_q;

  // Present FIFO heads to the FIU with valid reflecting an actual dequeue
  always_comb begin
    c0_head       = t_if_cci_mpf_c0_Tx'(c0_first);
    c0_head.valid = c0_deq;
    c1_head       = t_if_cci_mpf_c1_Tx'(c1_first);
    c1_head.valid = c1_deq;
  end

  assign fiu.c0Tx = c0_head;
  assign fiu.c1Tx = c1_head;

  // Sticky overflow: a request dropped because its FIFO was full and not popping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      if (afu.c0Tx.valid && c0_full && !c0_deq) err_q.c0 <= 1'b1;
      if (afu.c1Tx.valid && c1_full && !c1_deq) err_q.c1 <= 1'b1;
    end
  end

  assign overflow_err = err_q;

  // One-cycle retiming of MMIO responses and read/write responses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c2_tx_q <= '0;
      c0_rx_q <= '0;
      c1_rx_q <= '0;
    end else begin
      c2_tx_q <= afu.c2Tx;
      c0_rx_q <= fiu.c0Rx;
      c1_rx_q <= fiu.c1Rx;
    end
  end

  assign fiu.c2Tx = c2_tx_q;
  assign afu.c0Rx = c0_rx_q;
  assign afu.c1Rx = c1_rx_q;

  // Reset forwarded toward the AFU, stretched by one registered cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reset_q <= 1'b1;
    end else begin
      reset_q <= 1'b0;
    end
  end

  assign afu.reset       = reset_q;
  assign afu.c0TxAlmFull = c0_alm;
  assign afu.c1TxAlmFull = c1_alm;
endmodule

// File: tb/tb_cci_mpf_shim_tx_buffer.sv
// Randomized bench for cci_mpf_shim_tx_buffer against a queue-based reference model.
module tb_cci_mpf_shim_tx_buffer;
  import cci_mpf_if_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] overflow_err;

  cci_mpf_if fiu_if ();
  cci_mpf_if afu_if ();

  always #5 clk = ~clk;
  assign fiu_if.reset = reset;

  cci_mpf_shim_tx_buffer #(
    .DEPTH  (DEPTH),
    .THRESH (THRESH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fiu          (fiu_if),
    .afu          (afu_if),
    .overflow_err (overflow_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_out0 = 0;
  int n_out1 = 0;

  // reference model state
  t_if_cci_mpf_c0_Tx q0[$];
  t_if_cci_mpf_c1_Tx q1[$];
  logic              m_fiu_alm0, m_fiu_alm1;
  logic              m_alm0, m_alm1;
  logic [1:0]        m_err;
  logic              m_rst;
  t_if_cci_c2_Tx     m_c2;
  t_if_cci_c0_Rx     m_rx0;
  t_if_cci_c1_Rx     m_rx1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic t_if_cci_mpf_c0_Tx rnd_c0();
    t_if_cci_mpf_c0_Tx t;
    t.addr  = 42'({$urandom(), $urandom()});
    t.mdata = 16'($urandom());
    t.valid = 1'b1;
    return t;
  endfunction

  function automatic t_if_cci_mpf_c1_Tx rnd_c1();
    t_if_cci_mpf_c1_Tx t;
    t.addr  = 42'({$urandom(), $urandom()});
    t.mdata = 16'($urandom());
    t.data  = {$urandom(), $urandom()};
    t.sop   = 1'($urandom());
    t.valid = 1'b1;
    return t;
  endfunction

  function automatic t_if_cci_c2_Tx rnd_c2();
    t_if_cci_c2_Tx t;
    t.tid   = 9'($urandom());
    t.data  = {$urandom(), $urandom()};
    t.valid = 1'b1;
    return t;
  endfunction

  function automatic t_if_cci_c0_Rx rnd_rx0();
    t_if_cci_c0_Rx t;
    t.mdata = 16'($urandom());
    t.data  = {$urandom(), $urandom()};
    t.valid = 1'b1;
    return t;
  endfunction

  function automatic t_if_cci_c1_Rx rnd_rx1();
    t_if_cci_c1_Rx t;
    t.mdata = 16'($urandom());
    t.valid = 1'b1;
    return t;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_fiu_alm0 = 1'b1;
    m_fiu_alm1 = 1'b1;
    m_alm0     = 1'b1;
    m_alm1     = 1'b1;
    m_err      = 2'b00;
    m_rst      = 1'b1;
    m_c2       = '0;
    m_rx0      = '0;
    m_rx1      = '0;
  endtask

  task automatic idle();
    afu_if.c0Tx = '0;
    afu_if.c1Tx = '0;
    afu_if.c2Tx = '0;
    fiu_if.c0Rx = '0;
    fiu_if.c1Rx = '0;
  endtask

  // Check outputs mid-cycle, then advance the model across the next edge
  task automatic cycle();
    bit ev0, ev1;
    @(negedge clk);
    ev0 = (q0.size() > 0) && !m_fiu_alm0;
    ev1 = (q1.size() > 0) && !m_fiu_alm1;
    check("fiu_c0_valid", 256'(fiu_if.c0Tx.valid), 256'(ev0));
    if (ev0) check("fiu_c0_payload", 256'(fiu_if.c0Tx), 256'(q0[0]));
    check("fiu_c1_valid", 256'(fiu_if.c1Tx.valid), 256'(ev1));
    if (ev1) check("fiu_c1_payload", 256'(fiu_if.c1Tx), 256'(q1[0]));
    if (fiu_if.c0Tx.valid === 1'b1) n_out0++;
    if (fiu_if.c1Tx.valid === 1'b1) n_out1++;
    check("afu_c0_almfull", 256'(afu_if.c0TxAlmFull), 256'(m_alm0));
    check("afu_c1_almfull", 256'(afu_if.c1TxAlmFull), 256'(m_alm1));
    check("overflow_err", 256'(overflow_err), 256'(m_err));
    check("afu_reset", 256'(afu_if.reset), 256'(m_rst));
    check("fiu_c2_valid", 256'(fiu_if.c2Tx.valid), 256'(m_c2.valid));
    if (m_c2.valid) check("fiu_c2_payload", 256'(fiu_if.c2Tx), 256'(m_c2));
    check("afu_c0rx_valid", 256'(afu_if.c0Rx.valid), 256'(m_rx0.valid));
    if (m_rx0.valid) check("afu_c0rx_payload", 256'(afu_if.c0Rx), 256'(m_rx0));
    check("afu_c1rx_valid", 256'(afu_if.c1Rx.valid), 256'(m_rx1.valid));
    if (m_rx1.valid) check("afu_c1rx_payload", 256'(afu_if.c1Rx), 256'(m_rx1));
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (ev0) void'(q0.pop_front());
      if (ev1) void'(q1.pop_front());
      if (afu_if.c0Tx.valid) begin
        if (q0.size() < DEPTH) q0.push_back(afu_if.c0Tx);
        else m_err[0] = 1'b1;
      end
      if (afu_if.c1Tx.valid) begin
        if (q1.size() < DEPTH) q1.push_back(afu_if.c1Tx);
        else m_err[1] = 1'b1;
      end
      m_alm0     = (q0.size() >= DEPTH - THRESH);
      m_alm1     = (q1.size() >= DEPTH - THRESH);
      m_fiu_alm0 = fiu_if.c0TxAlmFull;
      m_fiu_alm1 = fiu_if.c1TxAlmFull;
      m_c2       = afu_if.c2Tx;
      m_rx0      = fiu_if.c0Rx;
      m_rx1      = fiu_if.c1Rx;
      m_rst      = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    idle();
    reset = 1'b1;
    model_reset();
    repeat (cycles) cycle();
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    int mark;
    reset = 1'b1;
    fiu_if.c0TxAlmFull = 1'b0;
    fiu_if.c1TxAlmFull = 1'b0;
    idle();
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    repeat (3) cycle();

    // single read passes through with one cycle of latency
    mark = n_out0;
    afu_if.c0Tx = rnd_c0();
    cycle();
    idle();
    repeat (4) cycle();
    check("pass_count", 256'(n_out0 - mark), 256'(1));

    // backpressure on c1: 12 writes held, then drained in order
    fiu_if.c1TxAlmFull = 1'b1;
    mark = n_out1;
    for (int i = 0; i < 12; i++) begin
      afu_if.c1Tx = rnd_c1();
      cycle();
    end
    idle();
    repeat (2) cycle();
    check("bp_held", 256'(n_out1 - mark), 256'(0));
    check("bp_afu_almfull", 256'(afu_if.c1TxAlmFull), 256'(1));
    fiu_if.c1TxAlmFull = 1'b0;
    repeat (16) cycle();
    check("bp_drain_count", 256'(n_out1 - mark), 256'(12));

    // overflow on c0: 17th request dropped
    fiu_if.c0TxAlmFull = 1'b1;
    mark = n_out0;
    for (int i = 0; i < 17; i++) begin
      afu_if.c0Tx = rnd_c0();
      cycle();
    end
    idle();
    cycle();
    check("ovf_flag", 256'(overflow_err), 256'(2'b01));
    fiu_if.c0TxAlmFull = 1'b0;
    repeat (20) cycle();
    check("ovf_drain_count", 256'(n_out0 - mark), 256'(16));
    check("ovf_sticky", 256'(overflow_err), 256'(2'b01));

    // full FIFO accepts a request in a cycle that also dequeues
    do_reset(2);
    fiu_if.c0TxAlmFull = 1'b1;
    mark = n_out0;
    for (int i = 0; i < 16; i++) begin
      afu_if.c0Tx = rnd_c0();
      cycle();
    end
    idle();
    fiu_if.c0TxAlmFull = 1'b0;
    cycle();
    afu_if.c0Tx = rnd_c0();
    cycle();
    idle();
    check("full_enqdeq_noerr", 256'(overflow_err), 256'(2'b00));
    repeat (20) cycle();
    check("full_enqdeq_count", 256'(n_out0 - mark), 256'(17));

    // response paths and random mixed traffic
    for (int i = 0; i < 300; i++) begin
      idle();
      if ($urandom_range(1, 0) == 1) afu_if.c0Tx = rnd_c0();
      if ($urandom_range(1, 0) == 1) afu_if.c1Tx = rnd_c1();
      if ($urandom_range(3, 0) == 0) afu_if.c2Tx = rnd_c2();
      if ($urandom_range(1, 0) == 1) fiu_if.c0Rx = rnd_rx0();
      if ($urandom_range(1, 0) == 1) fiu_if.c1Rx = rnd_rx1();
      fiu_if.c0TxAlmFull = ($urandom_range(3, 0) == 0);
      fiu_if.c1TxAlmFull = ($urandom_range(3, 0) == 0);
      cycle();
    end
    idle();
    fiu_if.c0TxAlmFull = 1'b0;
    fiu_if.c1TxAlmFull = 1'b0;
    repeat (20) cycle();

    // mid-run reset discards buffered writes
    do_reset(2);
    fiu_if.c1TxAlmFull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      afu_if.c1Tx = rnd_c1();
      cycle();
    end
    idle();
    reset = 1'b1;
    model_reset();
    fiu_if.c1TxAlmFull = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    mark = n_out1;
    repeat (10) cycle();
    check("rst_discard", 256'(n_out1 - mark), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
